// File: rtl/tone_synth.sv
// Tone synthesizer: fetches a 3-bit code over a four-phase request/ready handshake and plays it as a square wave.
// Latency: data_request rises one clock after reset release; each note is DUR_CYCLES of tone, then GAP_CYCLES of silence.
// Backpressure: waits in REQ until data_ready rises and in RELEASE until it falls; there is no timeout.
module tone_synth #(
   parameter int unsigned DUR_CYCLES = 25_000_000,
   parameter int unsigned GAP_CYCLES = 2_500_000,
   parameter int unsigned HP_SHIFT   = 0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [2:0] sound_code,
   input  logic       data_ready,
   output logic       data_request,
   output logic       speaker,
   output logic       playing,
   output logic [2:0] current_code
);

   localparam int DUR_W = (DUR_CYCLES > 1) ? $clog2(DUR_CYCLES) : 1;
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [DUR_W-1:0] DUR_LAST = DUR_W'(DUR_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      REQ     = 3'd1,
      RELEASE = 3'd2,
      PLAY    = 3'd3,
      GAP     = 3'd4
   } state_t;

   state_t            state;
   logic [DUR_W-1:0]  dur_cnt;
   logic [GAP_W-1:0]  gap_cnt;
   logic [16:0]       hp_cnt;
   logic [16:0]       half_period;
   logic [16:0]       hp_last;
   logic              is_rest;

   // Half-period counts of a 50 MHz clock for C4..B4.
   function automatic logic [16:0] hp_table(input logic [2:0] code);
      case (code)
         3'd1:    hp_table = 17'd95556;
         3'd2:    hp_table = 17'd85131;
         3'd3:    hp_table = 17'd75843;
         3'd4:    hp_table = 17'd71586;
         3'd5:    hp_table = 17'd63776;
         3'd6:    hp_table = 17'd56818;
         3'd7:    hp_table = 17'd50619;
         default: hp_table = 17'd0;
      endcase
   endfunction

   always_comb begin
      half_period = hp_table(current_code) >> HP_SHIFT;
      is_rest     = (half_period == 17'd0);
      hp_last     = half_period - 17'd1;
   end

   assign data_request = (state == REQ);
   assign playing      = (state == PLAY);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         speaker      <= 1'b0;
         current_code <= 3'd0;
         dur_cnt      <= '0;
         gap_cnt      <= '0;
         hp_cnt       <= '0;
      end else begin
         case (state)
            IDLE: state <= REQ;
            REQ: begin
               if (data_ready) begin
                  current_code <= sound_code;
                  state        <= RELEASE;
               end
            end
            RELEASE: begin
               if (!data_ready) begin
                  state   <= PLAY;
                  dur_cnt <= DUR_LAST;
                  hp_cnt  <= '0;
                  speaker <= 1'b0;
               end
            end
            PLAY: begin
               if (!is_rest) begin
                  if (hp_cnt == hp_last) begin
                     speaker <= ~speaker;
                     hp_cnt  <= '0;
                  end else begin
                     hp_cnt <= hp_cnt + 17'd1;
                  end
               end
               // Leaving PLAY overrides any toggle on the final clock.
               if (dur_cnt == '0) begin
                  state   <= GAP;
                  speaker <= 1'b0;
                  gap_cnt <= GAP_LAST;
               end else begin
                  dur_cnt <= dur_cnt - 1'b1;
               end
            end
            GAP: begin
               if (gap_cnt == '0) state <= REQ;
               else               gap_cnt <= gap_cnt - 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tone_synth.sv
// Bench for tone_synth: stimulus queues timestamped output-change events, a monitor pops and compares each change.
module tb_tone_synth;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] sound_code = 3'd0;
   logic       data_ready = 1'b0;
   logic       data_request;
   logic       speaker;
   logic       playing;
   logic [2:0] current_code;

   tone_synth #(
      .DUR_CYCLES(100),
      .GAP_CYCLES(10),
      .HP_SHIFT  (10)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .sound_code  (sound_code),
      .data_ready  (data_ready),
      .data_request(data_request),
      .speaker     (speaker),
      .playing     (playing),
      .current_code(current_code)
   );

   always #5 clock = ~clock;

   typedef struct {
      int         cyc;
      logic       dr;
      logic       pl;
      logic       sp;
      logic [2:0] cc;
   } ev_t;

   ev_t  exp_q[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   logic seeded = 1'b0;
   logic [5:0] last_obs;

   always @(posedge clock) cyc <= cyc + 1;

   function automatic void expect_ev(int c, logic dr, logic pl, logic sp, logic [2:0] cc);
      ev_t e;
      e.cyc = c; e.dr = dr; e.pl = pl; e.sp = sp; e.cc = cc;
      exp_q.push_back(e);
   endfunction

   // Every change of the observable outputs is one event to be matched.
   always @(negedge clock) begin
      logic [5:0] obs;
      ev_t e;
      obs = {data_request, playing, speaker, current_code};
      if (!seeded) begin
         seeded   = 1'b1;
         last_obs = obs;
      end else if (obs !== last_obs) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event cyc=%0d actual dr=%b pl=%b sp=%b cc=%0d required no change",
                     cyc, data_request, playing, speaker, current_code);
         end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.dr !== data_request || e.pl !== playing ||
                e.sp !== speaker || e.cc !== current_code) begin
               n_err++;
               $display("FAIL event actual cyc=%0d dr=%b pl=%b sp=%b cc=%0d required cyc=%0d dr=%b pl=%b sp=%b cc=%0d",
                        cyc, data_request, playing, speaker, current_code,
                        e.cyc, e.dr, e.pl, e.sp, e.cc);
            end
         end
         last_obs = obs;
      end
   end

   task automatic check(string name, int act, int req);
      n_cmp++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic tick(int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // One complete handshake + note + gap; hp is the shifted half-period (0 for rest).
   task automatic note(logic [2:0] code, int hp, int hold, logic [2:0] new_code, bit glitch);
      int c, p, t;
      logic sp;
      c = cyc;
      sound_code = code;
      data_ready = 1'b1;
      p = c + hold + 1;
      expect_ev(c + 1, 1'b0, 1'b0, 1'b0, code);
      expect_ev(p, 1'b0, 1'b1, 1'b0, code);
      sp = 1'b0;
      if (hp != 0) begin
         for (t = hp; t < 100; t += hp) begin
            sp = ~sp;
            expect_ev(p + t, 1'b0, 1'b1, sp, code);
         end
      end
      expect_ev(p + 100, 1'b0, 1'b0, 1'b0, code);
      expect_ev(p + 110, 1'b1, 1'b0, 1'b0, code);
      tick(hold);
      data_ready = 1'b0;
      tick(3);
      sound_code = new_code;
      if (glitch) begin
         tick(10);
         data_ready = 1'b1;
         tick(1);
         data_ready = 1'b0;
      end
      while (cyc < p + 112) tick(1);
   endtask

   task automatic release_reset();
      @(negedge clock);
      #1;
      expect_ev(cyc + 1, 1'b1, 1'b0, 1'b0, 3'd0);
      reset = 1'b0;
   endtask

   task automatic reset_mid_play();
      int c, p;
      c = cyc;
      sound_code = 3'd1;
      data_ready = 1'b1;
      p = c + 2;
      expect_ev(c + 1, 1'b0, 1'b0, 1'b0, 3'd1);
      expect_ev(p, 1'b0, 1'b1, 1'b0, 3'd1);
      expect_ev(p + 93, 1'b0, 1'b1, 1'b1, 3'd1);
      tick(1);
      data_ready = 1'b0;
      while (cyc < p + 95) tick(1);
      check("speaker_before_reset", int'(speaker), 1);
      expect_ev(p + 95, 1'b0, 1'b0, 1'b0, 3'd0);
      reset = 1'b1;
      #1;
      check("async_speaker", int'(speaker), 0);
      check("async_playing", int'(playing), 0);
      check("async_current_code", int'(current_code), 0);
      check("async_data_request", int'(data_request), 0);
      repeat (3) @(posedge clock);
      release_reset();
      tick(5);
   endtask

   initial begin
      tick(3);
      check("reset_data_request", int'(data_request), 0);
      check("reset_speaker", int'(speaker), 0);
      check("reset_playing", int'(playing), 0);
      check("reset_current_code", int'(current_code), 0);
      release_reset();
      tick(20);
      note(3'd6, 55, 1, 3'd6, 1'b0);
      note(3'd0, 0, 1, 3'd0, 1'b0);
      note(3'd1, 93, 1, 3'd7, 1'b1);
      note(3'd5, 62, 6, 3'd5, 1'b0);
      note(3'd7, 49, 1, 3'd7, 1'b0);
      reset_mid_play();
      note(3'd3, 74, 1, 3'd3, 1'b0);
      tick(20);
      check("pending_events", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
